// File: rtl/countdown_run.sv
// rtl/countdown_run.sv - HH:MM:SS BCD countdown timer with IDLE/RUN/DONE control.
// Optional setter-cursor blinking in IDLE is built when COUNTDOWN_BLINK_EN is defined.
module countdown_run #(
   parameter int CLK_HZ = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [31:0] preset,
   input  logic [3:0]  state,
   output logic [31:0] disp,
   output logic        running,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

   fsm_t          fsm_q, fsm_d;
   logic [PW-1:0] presc;
   logic          go_q;
   logic          armed;
   logic [3:0]    s1, s10, m1, m10, h1, h10;
   logic [3:0]    l_s1, l_s10, l_m1, l_m10, l_h1, l_h10;
   logic [3:0]    n_s1, n_s10, n_m1, n_m10, n_h1, n_h10;
   logic          go_rise, tick, load_zero, dec_zero;
   logic          running_q, done_q;

   // armed is only set once go has been seen low, so a go held across reset cannot start a run
   assign go_rise = go && !go_q && armed;
   assign tick    = (fsm_q == RUN) && (presc == TERM);

   always_comb begin
      l_s1  = (preset[3:0]   > 4'd9) ? 4'd9 : preset[3:0];
      l_s10 = (preset[7:4]   > 4'd5) ? 4'd5 : preset[7:4];
      l_m1  = (preset[15:12] > 4'd9) ? 4'd9 : preset[15:12];
      l_m10 = (preset[19:16] > 4'd5) ? 4'd5 : preset[19:16];
      l_h1  = (preset[27:24] > 4'd9) ? 4'd9 : preset[27:24];
      l_h10 = (preset[31:28] > 4'd9) ? 4'd9 : preset[31:28];
      load_zero = ({l_h10, l_h1, l_m10, l_m1, l_s10, l_s1} == 24'd0);
   end

   always_comb begin
      n_s1 = s1; n_s10 = s10; n_m1 = m1; n_m10 = m10; n_h1 = h1; n_h10 = h10;
      if (s1 != 4'd0) n_s1 = s1 - 4'd1;
      else begin
         n_s1 = 4'd9;
         if (s10 != 4'd0) n_s10 = s10 - 4'd1;
         else begin
            n_s10 = 4'd5;
            if (m1 != 4'd0) n_m1 = m1 - 4'd1;
            else begin
               n_m1 = 4'd9;
               if (m10 != 4'd0) n_m10 = m10 - 4'd1;
               else begin
                  n_m10 = 4'd5;
                  if (h1 != 4'd0) n_h1 = h1 - 4'd1;
                  else begin
                     n_h1  = 4'd9;
                     n_h10 = (h10 != 4'd0) ? h10 - 4'd1 : 4'd9;
                  end
               end
            end
         end
      end
      dec_zero = ({n_h10, n_h1, n_m10, n_m1, n_s10, n_s1} == 24'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= IDLE;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         running_q <= (fsm_d == RUN);
         done_q    <= (fsm_d == DONE);
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (go_rise) fsm_d = load_zero ? DONE : RUN;
         RUN:     if (!go) fsm_d = IDLE;
                  else if (tick && dec_zero) fsm_d = DONE;
         DONE:    if (!go) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         go_q  <= 1'b0;
         armed <= 1'b0;
         {h10, h1, m10, m1, s10, s1} <= 24'd0;
      end else begin
         go_q <= go;
         if (!go) armed <= 1'b1;
         if (fsm_q == IDLE && go_rise) begin
            presc <= '0;
            {h10, h1, m10, m1, s10, s1} <= {l_h10, l_h1, l_m10, l_m1, l_s10, l_s1};
         end else if (fsm_q == RUN && go) begin
            if (tick) begin
               presc <= '0;
               {h10, h1, m10, m1, s10, s1} <= {n_h10, n_h1, n_m10, n_m1, n_s10, n_s1};
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

`ifdef COUNTDOWN_BLINK_EN
   localparam int HALF = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

   logic [BW-1:0] blink_cnt;
   logic          blink_ph;

   // blink_ph flips every HALF cycles; the cursor nibble is blanked while it is high
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (blink_cnt == BW'(HALF - 1)) begin
         blink_cnt <= '0;
         blink_ph  <= !blink_ph;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end
`else
   logic unused_state;
   assign unused_state = ^state;
`endif

   always_comb begin
      disp = preset;
      case (fsm_q)
         IDLE: begin
`ifdef COUNTDOWN_BLINK_EN
            if (blink_ph) begin
               case (state)
                  4'd1:    disp[3:0]   = 4'hF;
                  4'd2:    disp[7:4]   = 4'hF;
                  4'd3:    disp[15:12] = 4'hF;
                  4'd4:    disp[19:16] = 4'hF;
                  4'd5:    disp[27:24] = 4'hF;
                  4'd6:    disp[31:28] = 4'hF;
                  default: disp = preset;
               endcase
            end
`endif
         end
         RUN:     disp = {h10, h1, 4'hF, m10, m1, 4'hF, s10, s1};
         DONE:    disp = 32'h00F0_0F00;
         default: disp = preset;
      endcase
   end

   assign running = running_q;
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_run.sv
// tb/tb_countdown_run.sv - directed-vector bench for countdown_run at CLK_HZ = 10.
module tb_countdown_run;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [31:0] preset;
   logic [3:0]  state;
   logic [31:0] disp;
   logic        running;
   logic        done;

   int vectors = 0;
   int miscompares = 0;

   countdown_run #(.CLK_HZ(10)) dut (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .preset  (preset),
      .state   (state),
      .disp    (disp),
      .running (running),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; state = 4'd0; preset = 32'h12F3_4F56;
      step(2);
      chk("reset_running", {31'd0, running}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_disp", disp, 32'h12F3_4F56);
      rst = 1'b0;
      step(1);

      // 00:00:12 counts down, first tick exactly 10 cycles after load
      preset = 32'h00F0_0F12; go = 1'b1;
      step(1);
      chk("load_running", {31'd0, running}, 32'd1);
      chk("load_disp", disp, 32'h00F0_0F12);
      step(9);
      chk("pre_tick_disp", disp, 32'h00F0_0F12);
      step(1);
      chk("tick1_disp", disp, 32'h00F0_0F11);
      step(10);
      chk("tick2_disp", disp, 32'h00F0_0F10);
      step(99);
      chk("c119_disp", disp, 32'h00F0_0F01);
      chk("c119_done", {31'd0, done}, 32'd0);
      step(1);
      chk("c120_done", {31'd0, done}, 32'd1);
      chk("c120_running", {31'd0, running}, 32'd0);
      chk("c120_disp", disp, 32'h00F0_0F00);
      go = 1'b0;
      step(1);
      chk("done_exit_done", {31'd0, done}, 32'd0);
      chk("done_exit_disp", disp, 32'h00F0_0F12);

      // borrow across minutes and hours
      preset = 32'h01F0_0F00; go = 1'b1;
      step(11);
      chk("borrow_hr1", disp, 32'h00F5_9F59);
      go = 1'b0;
      step(1);
      preset = 32'h10F0_0F00; go = 1'b1;
      step(11);
      chk("borrow_hr10", disp, 32'h09F5_9F59);
      chk("borrow_running", {31'd0, running}, 32'd1);
      go = 1'b0;
      step(1);

      // all-zero load goes straight to DONE
      preset = 32'h00F0_0F00; go = 1'b1;
      step(1);
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_running", {31'd0, running}, 32'd0);
      step(3);
      chk("zero_running_hold", {31'd0, running}, 32'd0);
      go = 1'b0;
      step(1);

      // saturation of tens digits, hours unchanged
      preset = 32'h23F8_FF7F; go = 1'b1;
      step(1);
      chk("sat_load", disp, 32'h23F5_9F59);
      step(10);
      chk("sat_tick", disp, 32'h23F5_9F58);
      go = 1'b0;
      step(1);
      chk("golow_running", {31'd0, running}, 32'd0);
      chk("golow_disp", disp, 32'h23F8_FF7F);
      preset = 32'h0CF0_0F01; go = 1'b1;
      step(1);
      chk("sat_hr1", disp, 32'h09F0_0F01);
      go = 1'b0;
      step(1);

      // reset mid-RUN with go held high
      preset = 32'h00F0_0F30; go = 1'b1;
      step(5);
      chk("prerst_running", {31'd0, running}, 32'd1);
      rst = 1'b1;
      step(1);
      chk("rst_run_running", {31'd0, running}, 32'd0);
      chk("rst_run_disp", disp, 32'h00F0_0F30);
      rst = 1'b0;
      step(15);
      chk("no_restart_running", {31'd0, running}, 32'd0);
      chk("no_restart_done", {31'd0, done}, 32'd0);
      go = 1'b0;
      step(1);
      go = 1'b1;
      step(1);
      chk("restart_running", {31'd0, running}, 32'd1);
      step(10);
      chk("restart_tick", disp, 32'h00F0_0F29);

      // reset while in DONE
      go = 1'b0;
      step(1);
      preset = 32'h00F0_0F00; go = 1'b1;
      step(1);
      chk("predone_done", {31'd0, done}, 32'd1);
      rst = 1'b1;
      step(1);
      chk("rst_done_done", {31'd0, done}, 32'd0);
      rst = 1'b0; go = 1'b0;
      step(1);

`ifdef COUNTDOWN_BLINK_EN
      begin
         int blanks;
         preset = 32'h12F3_4F56; state = 4'd3; blanks = 0;
         for (int i = 0; i < 20; i++) begin
            step(1);
            if (disp[15:12] == 4'hF) blanks++;
            chk("blink_other", {disp[31:16], disp[11:0]}, {16'h12F3, 12'hF56});
         end
         chk("blink_count", blanks, 10);
         state = 4'd0; blanks = 0;
         for (int i = 0; i < 20; i++) begin
            step(1);
            if (disp != preset) blanks++;
         end
         chk("blink_none", blanks, 0);
      end
`else
      preset = 32'h12F3_4F56; state = 4'd3;
      step(7);
      chk("noblink_disp", disp, 32'h12F3_4F56);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
